rmii_mii_bridge: RTL and testbench
==================================

// Module: rmii_mii_bridge
// PURPOSE
//  Parametrised successor to the fixed-rate RMII-to-MII converter: joins the 2-bit RMII PHY to the 4-bit MII nibble side of hermes_lite_core.
//  Adds run-time 10/100 Mb/s selection, a preamble/SFD-locked RX nibble aligner and CRS_DV toggle decoding.
//  Adds a dangling-dibit error flag and a frame counter.
//  Runs entirely on the 50 MHz rmii_osc; nibble timing uses one-cycle strobes, not derived MII clocks.
// PARAMETERS
//  DIV10  10  clk cycles per dibit in 10 Mb/s mode (>=4)
//  CNT_W  16  width of rx_frames counter
// PORTS
//  clk          in   1      RMII REF_CLK (50 MHz)
//  resetn       in   1      asynchronous, active-low reset
//  speed100     in   1      1=100 Mb/s, 0=10 Mb/s; applied only when RX and TX both idle
//  phy_rxd      in   2      RMII receive dibit
//  phy_crs_dv   in   1      RMII carrier-sense/data-valid
//  mac_rxd      out  4      received nibble, valid when mac_rx_stb=1
//  mac_rx_dv    out  1      high from first data nibble to end of frame
//  mac_rx_stb   out  1      one-cycle pulse per new nibble
//  mac_rx_err   out  1      one-cycle pulse: frame ended on odd dibit
//  rx_frames    out  CNT_W  count of cleanly ended frames, wraps
//  mac_txd      in   4      transmit nibble
//  mac_tx_en    in   1      MAC has a nibble to send
//  mac_tx_stb   out  1      pulse: mac_txd consumed this cycle; next nibble due next cycle
//  phy_txd      out  2      RMII transmit dibit
//  phy_tx_en    out  1      RMII transmit enable
// BEHAVIOUR
//  Reset: all outputs 0, RX/TX FSMs IDLE, mode latched from speed100 on reset release.
//   Reset mid-frame aborts the frame silently; next frame requires fresh preamble.
//  Mode register updates from speed100 only on a cycle where both FSMs are IDLE.
//  RX sampling: phy_rxd/phy_crs_dv registered once.
//   100M: sample point every cycle.
//   10M: divide counter restarts on crs_dv rise; sample at count DIV10/2, then every DIV10.
//  RX FSM:
//   IDLE: crs_dv=1 at sample -> PRE.
//   PRE: dibit 01 seen then dibit 11 -> DATA, phase=0. Two consecutive crs_dv=0 samples -> IDLE
//    (false carrier: no dv, no stb, no count).
//   DATA: phase0 dibit -> nib[1:0]; phase1 dibit -> nib[3:2], drive mac_rxd, mac_rx_stb=1, mac_rx_dv=1.
//  CRS_DV end rule:
//   A crs_dv=0 sample is held provisionally. Next sample 1 -> provisional dibit is data, continue.
//   Next sample 0 -> frame end; both low dibits discarded.
//   Held dibit at phase0 -> clean end: rx_frames+1.
//   Held dibit at phase1 -> mac_rx_err pulse, no count.
//   mac_rx_dv clears the cycle after end detection; FSM -> IDLE.
//  RX latency: mac_rx_stb 2 cycles after the completing dibit on pins (100M).
//  TX FSM:
//   IDLE: mac_tx_en=1 -> mac_tx_stb pulse, latch nibble, -> SEND.
//   SEND: next cycle phy_tx_en=1, phy_txd=nib[1:0]; after one dibit time (1 cycle 100M, DIV10 cycles 10M) phy_txd=nib[3:2].
//   Last cycle of second dibit: mac_tx_en=1 -> stb pulse and latch, seamless continuation.
//   Otherwise phy_tx_en=0, phy_txd=00 next cycle -> IDLE.
//   phy_txd/phy_tx_en registered; mac_txd sampled only on stb cycles.
//  Simultaneous RX and TX operation is independent; no collision handling.
//  rx_frames wraps 2^CNT_W-1 -> 0.
// TESTING
//  1 100M RX: 7x0x55, 0xD5, 0x12, 0x34, crs_dv toggle end -> stb every 2 cycles, mac_rxd 2,1,4,3, dv high throughout, rx_frames 0->1.
//  2 100M RX odd end: same frame plus one extra dibit then crs_dv=0,0 -> mac_rx_err one pulse, rx_frames unchanged, dv drops.
//  3 10M RX (speed100=0): same frame, dibits held 10 cycles -> stb every 20 cycles, identical nibbles, rx_frames +1.
//  4 100M TX: mac_tx_en for nibbles 5,5,D,3 -> phy_txd 01,01,01,01,01,11,11,00; stb every 2 cycles; tx_en low after 8 dibits.
//  5 10M TX: nibble A -> phy_txd 10 for 10 cycles then 10 for 10 cycles; single stb; tx_en 20 cycles.
//  6 Boundaries:
//   - speed100 toggled mid-frame -> mode changes only after frame end.
//   - resetn low mid-frame -> outputs 0 immediately, next frame decoded correctly.
//   - crs_dv 3-cycle pulse without SFD -> no stb.
//   - rx_frames at 0xFFFF plus one clean frame -> 0x0000.

Source files
------------

// File: rtl/rmii_mii_bridge.sv
// RMII (2-bit, 50 MHz) to MII-nibble bridge with run-time 10/100 Mb/s selection.
// Latency: RX nibble strobe 2 clk after its completing dibit on pins (100M); TX first dibit 1 clk after mac_tx_stb.
// Backpressure: none on RX (MAC must take every strobe); TX paces the MAC by pulsing mac_tx_stb once per nibble.
//
// Ports
//   clk, resetn                 50 MHz RMII reference clock, async active-low reset
//   speed100                    1 = 100 Mb/s, 0 = 10 Mb/s; taken only while RX and TX are both idle
//   phy_rxd, phy_crs_dv         RMII receive dibit and carrier-sense/data-valid
//   mac_rxd, mac_rx_stb         received nibble and its one-cycle strobe
//   mac_rx_dv, mac_rx_err       frame-active flag, odd-dibit frame-end pulse
//   rx_frames                   wrapping count of cleanly ended frames
//   mac_txd, mac_tx_en          MAC transmit nibble and request
//   mac_tx_stb                  mac_txd consumed this cycle
//   phy_txd, phy_tx_en          RMII transmit dibit and enable
module rmii_mii_bridge #(
    parameter int DIV10 = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             speed100,
    input  logic [1:0]       phy_rxd,
    input  logic             phy_crs_dv,
    output logic [3:0]       mac_rxd,
    output logic             mac_rx_dv,
    output logic             mac_rx_stb,
    output logic             mac_rx_err,
    output logic [CNT_W-1:0] rx_frames,
    input  logic [3:0]       mac_txd,
    input  logic             mac_tx_en,
    output logic             mac_tx_stb,
    output logic [1:0]       phy_txd,
    output logic             phy_tx_en
);

    localparam int DW = $clog2(DIV10);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV10 - 1);
    localparam logic [DW-1:0] DIV_MID  = DW'(DIV10 / 2);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_PRE  = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_D0   = 2'd1;
    localparam logic [1:0] TX_D1   = 2'd2;

    // ------------------------------------------------------------------
    // Common state
    // ------------------------------------------------------------------
    logic run_q;       // low for the first cycle after reset so no TX strobe leaks out of reset
    logic mode100_q;

    // ------------------------------------------------------------------
    // RX input registers and 10M sample-point generator
    // ------------------------------------------------------------------
    logic [1:0]    rxd_q;
    logic          crs_q, crs_prev_q;
    logic [DW-1:0] rdiv_q, rdiv_cur, rdiv_d;
    logic          crs_rise, rx_samp;

    assign crs_rise = crs_q & ~crs_prev_q;
    // A carrier rise re-phases the divider so samples land mid-dibit.
    assign rdiv_cur = crs_rise ? '0 : rdiv_q;
    assign rdiv_d   = (rdiv_cur == DIV_LAST) ? '0 : rdiv_cur + DW'(1);
    assign rx_samp  = mode100_q | (rdiv_cur == DIV_MID);

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    logic [1:0]       rx_st_q, rx_st_d;
    logic             seen01_q, seen01_d;
    logic             pre_low_q, pre_low_d;
    logic             ph_q, ph_d;
    logic [1:0]       lo_q, lo_d;
    logic             hold_q, hold_d;      // a crs_dv=0 dibit awaiting its verdict
    logic [1:0]       held_q, held_d;
    logic [3:0]       rxn_q, rxn_d;
    logic             rx_stb_q, rx_stb_d;
    logic             rx_dv_q, rx_dv_d;
    logic             rx_err_q, rx_err_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    always_comb begin
        rx_st_d   = rx_st_q;
        seen01_d  = seen01_q;
        pre_low_d = pre_low_q;
        ph_d      = ph_q;
        lo_d      = lo_q;
        hold_d    = hold_q;
        held_d    = held_q;
        rxn_d     = rxn_q;
        rx_stb_d  = 1'b0;
        rx_dv_d   = rx_dv_q;
        rx_err_d  = 1'b0;
        frames_d  = frames_q;

        if (rx_samp) begin
            case (rx_st_q)
                RX_IDLE: begin
                    if (crs_q) begin
                        rx_st_d   = RX_PRE;
                        seen01_d  = (rxd_q == 2'b01);
                        pre_low_d = 1'b0;
                    end
                end
                RX_PRE: begin
                    if (crs_q) begin
                        pre_low_d = 1'b0;
                        if (seen01_q && rxd_q == 2'b11) begin
                            rx_st_d = RX_DATA;
                            ph_d    = 1'b0;
                            hold_d  = 1'b0;
                        end else begin
                            seen01_d = (rxd_q == 2'b01);
                        end
                    end else if (pre_low_q) begin
                        // false carrier: drop silently
                        rx_st_d = RX_IDLE;
                    end else begin
                        pre_low_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    if (!crs_q) begin
                        if (!hold_q) begin
                            hold_d = 1'b1;
                            held_d = rxd_q;
                        end else begin
                            // Two low samples: frame over, both low dibits discarded.
                            rx_st_d = RX_IDLE;
                            hold_d  = 1'b0;
                            rx_dv_d = 1'b0;
                            if (!ph_q) frames_d = frames_q + CNT_W'(1);
                            else       rx_err_d = 1'b1;
                        end
                    end else if (hold_q) begin
                        // Low sample was a CRS_DV toggle: held dibit and this one are both data.
                        hold_d   = 1'b0;
                        rx_stb_d = 1'b1;
                        rx_dv_d  = 1'b1;
                        if (!ph_q) begin
                            rxn_d = {rxd_q, held_q};
                        end else begin
                            rxn_d = {held_q, lo_q};
                            lo_d  = rxd_q;
                        end
                    end else if (!ph_q) begin
                        lo_d = rxd_q;
                        ph_d = 1'b1;
                    end else begin
                        rxn_d    = {rxd_q, lo_q};
                        rx_stb_d = 1'b1;
                        rx_dv_d  = 1'b1;
                        ph_d     = 1'b0;
                    end
                end
                default: rx_st_d = RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    logic [1:0]    tx_st_q, tx_st_d;
    logic [DW-1:0] tdiv_q, tdiv_d;
    logic [1:0]    tx_hi_q, tx_hi_d;     // upper dibit of the nibble in flight
    logic [1:0]    ptxd_q, ptxd_d;
    logic          ptxen_q, ptxen_d;
    logic          tlast, tx_take;

    assign tlast   = mode100_q | (tdiv_q == DIV_LAST);
    assign tx_take = run_q & mac_tx_en &
                     ((tx_st_q == TX_IDLE) | ((tx_st_q == TX_D1) & tlast));

    always_comb begin
        tx_st_d = tx_st_q;
        tdiv_d  = tdiv_q;
        tx_hi_d = tx_hi_q;
        ptxd_d  = ptxd_q;
        ptxen_d = ptxen_q;

        if (tx_take) begin
            tx_hi_d = mac_txd[3:2];
            ptxd_d  = mac_txd[1:0];
            ptxen_d = 1'b1;
            tx_st_d = TX_D0;
            tdiv_d  = '0;
        end else begin
            case (tx_st_q)
                TX_D0: begin
                    if (tlast) begin
                        ptxd_d  = tx_hi_q;
                        tx_st_d = TX_D1;
                        tdiv_d  = '0;
                    end else begin
                        tdiv_d = tdiv_q + DW'(1);
                    end
                end
                TX_D1: begin
                    if (tlast) begin
                        ptxd_d  = 2'b00;
                        ptxen_d = 1'b0;
                        tx_st_d = TX_IDLE;
                        tdiv_d  = '0;
                    end else begin
                        tdiv_d = tdiv_q + DW'(1);
                    end
                end
                default: tx_st_d = TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q      <= 1'b0;
            mode100_q  <= 1'b1;
            rxd_q      <= 2'b00;
            crs_q      <= 1'b0;
            crs_prev_q <= 1'b0;
            rdiv_q     <= '0;
            rx_st_q    <= RX_IDLE;
            seen01_q   <= 1'b0;
            pre_low_q  <= 1'b0;
            ph_q       <= 1'b0;
            lo_q       <= 2'b00;
            hold_q     <= 1'b0;
            held_q     <= 2'b00;
            rxn_q      <= 4'h0;
            rx_stb_q   <= 1'b0;
            rx_dv_q    <= 1'b0;
            rx_err_q   <= 1'b0;
            frames_q   <= '0;
            tx_st_q    <= TX_IDLE;
            tdiv_q     <= '0;
            tx_hi_q    <= 2'b00;
            ptxd_q     <= 2'b00;
            ptxen_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            // Mode only moves between frames; the first cycle after reset is always idle.
            if (rx_st_q == RX_IDLE && tx_st_q == TX_IDLE) mode100_q <= speed100;
            rxd_q      <= phy_rxd;
            crs_q      <= phy_crs_dv;
            crs_prev_q <= crs_q;
            rdiv_q     <= rdiv_d;
            rx_st_q    <= rx_st_d;
            seen01_q   <= seen01_d;
            pre_low_q  <= pre_low_d;
            ph_q       <= ph_d;
            lo_q       <= lo_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            rxn_q      <= rxn_d;
            rx_stb_q   <= rx_stb_d;
            rx_dv_q    <= rx_dv_d;
            rx_err_q   <= rx_err_d;
            frames_q   <= frames_d;
            tx_st_q    <= tx_st_d;
            tdiv_q     <= tdiv_d;
            tx_hi_q    <= tx_hi_d;
            ptxd_q     <= ptxd_d;
            ptxen_q    <= ptxen_d;
        end
    end

    assign mac_rxd    = rxn_q;
    assign mac_rx_stb = rx_stb_q;
    assign mac_rx_dv  = rx_dv_q;
    assign mac_rx_err = rx_err_q;
    assign rx_frames  = frames_q;
    assign mac_tx_stb = tx_take;
    assign phy_txd    = ptxd_q;
    assign phy_tx_en  = ptxen_q;

endmodule

// File: tb/tb_rmii_mii_bridge.sv
// Scoreboard bench for rmii_mii_bridge: directed frames push expected nibbles/dibits,
// independent monitors pop and compare whenever the DUT strobes.
// Small counter width so the wrap case stays short.
module tb_rmii_mii_bridge;
    localparam int DIV10 = 10;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             speed100;
    logic [1:0]       phy_rxd;
    logic             phy_crs_dv;
    logic [3:0]       mac_rxd;
    logic             mac_rx_dv, mac_rx_stb, mac_rx_err;
    logic [CNT_W-1:0] rx_frames;
    logic [3:0]       mac_txd;
    logic             mac_tx_en, mac_tx_stb;
    logic [1:0]       phy_txd;
    logic             phy_tx_en;

    rmii_mii_bridge #(.DIV10(DIV10), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .speed100(speed100),
        .phy_rxd(phy_rxd), .phy_crs_dv(phy_crs_dv),
        .mac_rxd(mac_rxd), .mac_rx_dv(mac_rx_dv), .mac_rx_stb(mac_rx_stb),
        .mac_rx_err(mac_rx_err), .rx_frames(rx_frames),
        .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_stb(mac_tx_stb),
        .phy_txd(phy_txd), .phy_tx_en(phy_tx_en)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [3:0] exp_nib[$];
    logic [1:0] exp_dib[$];
    int         exp_burst[$];
    int         cyc = 0;
    int         exp_gap = 2;
    int         rx_stb_n = 0, rx_err_n = 0, tx_stb_n = 0;
    int         last_stb_cyc = 0;
    bit         in_frame = 0;
    int         burst_len = 0;
    int         exp_frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RX monitor
    always @(negedge clk) begin
        if (mac_rx_stb) begin
            rx_stb_n++;
            if (exp_nib.size() == 0) chk("rx_unexpected_stb", 1, 0);
            else                     chk("rx_nibble", mac_rxd, exp_nib.pop_front());
            chk("rx_dv_with_stb", mac_rx_dv, 1);
            if (in_frame) chk("rx_stb_spacing", cyc - last_stb_cyc, exp_gap);
            in_frame     = 1;
            last_stb_cyc = cyc;
        end else if (!mac_rx_dv) begin
            in_frame = 0;
        end
        if (mac_rx_err) rx_err_n++;
    end

    // TX monitor
    always @(negedge clk) begin
        if (mac_tx_stb) tx_stb_n++;
        if (phy_tx_en) begin
            burst_len++;
            if (exp_dib.size() == 0) chk("tx_unexpected_dibit", 1, 0);
            else                     chk("tx_dibit", phy_txd, exp_dib.pop_front());
        end else if (burst_len != 0) begin
            if (exp_burst.size() == 0) chk("tx_unexpected_burst", 1, 0);
            else                       chk("tx_burst_len", burst_len, exp_burst.pop_front());
            chk("tx_idle_txd", phy_txd, 0);
            burst_len = 0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [1:0] d, input logic c, input int n);
        phy_rxd    = d;
        phy_crs_dv = c;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Preamble x7, SFD, payload 0x12 0x34. odd: dangling dibit before end.
    // Clean frames end with a CRS_DV toggle on the last nibble.
    task automatic rx_frame(input int hold, input bit odd, input bit flip_speed);
        exp_gap = 2 * hold;
        exp_nib.push_back(4'h2);
        exp_nib.push_back(4'h1);
        exp_nib.push_back(4'h4);
        exp_nib.push_back(4'h3);
        for (int i = 0; i < 31; i++) drive(2'b01, 1'b1, hold);
        drive(2'b11, 1'b1, hold);
        if (flip_speed) speed100 = 1'b0;
        drive(2'b10, 1'b1, hold);
        drive(2'b00, 1'b1, hold);
        drive(2'b01, 1'b1, hold);
        drive(2'b00, 1'b1, hold);
        drive(2'b00, 1'b1, hold);
        drive(2'b01, 1'b1, hold);
        if (odd) begin
            drive(2'b11, 1'b1, hold);
            drive(2'b00, 1'b1, hold);
            drive(2'b10, 1'b1, hold);
        end else begin
            drive(2'b11, 1'b0, hold);
            drive(2'b00, 1'b1, hold);
        end
        drive(2'b00, 1'b0, 2 * hold + 6);
    endtask

    task automatic tx_send(input int n, input logic [15:0] nibs, input int hold);
        logic [3:0] nb;
        int t;
        exp_burst.push_back(n * 2 * hold);
        for (int i = 0; i < n; i++) begin
            nb = nibs[4*i +: 4];
            repeat (hold) exp_dib.push_back(nb[1:0]);
            repeat (hold) exp_dib.push_back(nb[3:2]);
        end
        mac_tx_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            mac_txd = nibs[4*i +: 4];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!mac_tx_stb && t < 100);
            if (!mac_tx_stb) chk("tx_stb_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        mac_tx_en = 1'b0;
        mac_txd   = 4'h0;
        repeat (2 * hold + 6) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_of_rx(input string tag, input int err_exp);
        chk({tag, "_frames"}, rx_frames, exp_frames);
        chk({tag, "_err_count"}, rx_err_n, err_exp);
        chk({tag, "_nibbles_left"}, exp_nib.size(), 0);
        chk({tag, "_dv_low"}, mac_rx_dv, 0);
    endtask

    initial begin
        resetn     = 1'b0;
        speed100   = 1'b1;
        phy_rxd    = 2'b00;
        phy_crs_dv = 1'b0;
        mac_txd    = 4'h7;
        mac_tx_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // reset state, with a TX request pending that must not be strobed
        chk("rst_mac_rxd", mac_rxd, 0);
        chk("rst_rx_dv", mac_rx_dv, 0);
        chk("rst_rx_stb", mac_rx_stb, 0);
        chk("rst_rx_err", mac_rx_err, 0);
        chk("rst_frames", rx_frames, 0);
        chk("rst_tx_stb", mac_tx_stb, 0);
        chk("rst_phy_txd", phy_txd, 0);
        chk("rst_phy_tx_en", phy_tx_en, 0);
        mac_tx_en = 1'b0;
        mac_txd   = 4'h0;
        resetn    = 1'b1;
        drive(2'b00, 1'b0, 4);

        // 100M clean frame
        rx_frame(1, 0, 0);
        exp_frames = 1;
        end_of_rx("t1", 0);
        chk("t1_stb_count", rx_stb_n, 4);

        // 100M odd end
        rx_frame(1, 1, 0);
        end_of_rx("t2", 1);

        // 100M TX 5,5,D,3
        tx_send(4, 16'h3D55, 1);
        chk("t4_tx_stb_count", tx_stb_n, 4);
        chk("t4_dibits_left", exp_dib.size(), 0);
        chk("t4_bursts_left", exp_burst.size(), 0);

        // speed100 dropped mid-frame: frame still decoded at 100M spacing
        rx_frame(1, 0, 1);
        exp_frames = 2;
        end_of_rx("speed_flip", 1);

        // 10M clean frame, now in effect
        rx_frame(DIV10, 0, 0);
        exp_frames = 3;
        end_of_rx("t3", 1);
        chk("t3_stb_count", rx_stb_n, 16);

        // 10M TX nibble A
        tx_send(1, 16'h000A, DIV10);
        chk("t5_tx_stb_count", tx_stb_n, 5);
        chk("t5_dibits_left", exp_dib.size(), 0);
        chk("t5_bursts_left", exp_burst.size(), 0);

        speed100 = 1'b1;
        drive(2'b00, 1'b0, 4);

        // false carrier without SFD
        drive(2'b01, 1'b1, 3);
        drive(2'b00, 1'b0, 8);
        end_of_rx("false_crs", 1);
        chk("false_crs_stb_count", rx_stb_n, 16);

        // reset mid-frame after two nibbles
        exp_gap = 2;
        exp_nib.push_back(4'h2);
        exp_nib.push_back(4'h1);
        for (int i = 0; i < 31; i++) drive(2'b01, 1'b1, 1);
        drive(2'b11, 1'b1, 1);
        drive(2'b10, 1'b1, 1);
        drive(2'b00, 1'b1, 1);
        drive(2'b01, 1'b1, 1);
        drive(2'b00, 1'b1, 1);
        drive(2'b00, 1'b1, 1);
        drive(2'b00, 1'b0, 1);
        chk("midrst_dv_before", mac_rx_dv, 1);
        chk("midrst_nibbles_seen", exp_nib.size(), 0);
        resetn = 1'b0;
        #1;
        chk("midrst_dv", mac_rx_dv, 0);
        chk("midrst_stb", mac_rx_stb, 0);
        chk("midrst_rxd", mac_rxd, 0);
        chk("midrst_frames", rx_frames, 0);
        exp_frames = 0;
        drive(2'b01, 1'b1, 2);
        resetn = 1'b1;
        drive(2'b00, 1'b0, 3);
        rx_frame(1, 0, 0);
        exp_frames = 1;
        end_of_rx("post_rst", 1);

        // counter wrap: minimal frames up to all-ones, then one more
        for (int i = 0; i < (1 << CNT_W) - 2; i++) begin
            drive(2'b01, 1'b1, 1);
            drive(2'b11, 1'b1, 1);
            drive(2'b00, 1'b0, 3);
        end
        drive(2'b00, 1'b0, 2);
        chk("wrap_all_ones", rx_frames, (1 << CNT_W) - 1);
        rx_frame(1, 0, 0);
        exp_frames = 0;
        end_of_rx("wrap", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
